// File: rtl/ctrl_decoder.sv
// Main control decoder for the 9-bit CPU: opcode -> datapath strobes,
// combinational for same-cycle use plus a registered copy for the next stage.
module ctrl_decoder #(
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  output logic           str,
  output logic           ldr,
  output logic           rf_we,
  output logic           branch,
  output logic           imm_sel,
  output logic [1:0]     alu_op,
  output logic [OPW-1:0] op_q,
  output logic           str_q,
  output logic           ldr_q,
  output logic           rf_we_q,
  output logic           branch_q
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_AND = OPW'(1);
  localparam logic [OPW-1:0] OP_XOR = OPW'(2);
  localparam logic [OPW-1:0] OP_LSH = OPW'(3);
  localparam logic [OPW-1:0] OP_LDI = OPW'(4);
  localparam logic [OPW-1:0] OP_STR = OPW'(5);
  localparam logic [OPW-1:0] OP_LDM = OPW'(6);
  localparam logic [OPW-1:0] OP_BNE = OPW'(7);

  logic [OPW-1:0] op_d;
  logic           str_d;
  logic           ldr_d;
  logic           rf_we_d;
  logic           branch_d;

  // An opcode with X/Z bits matches no item and falls to the all-zero safe state.
  always_comb begin
    str     = 1'b0;
    ldr     = 1'b0;
    rf_we   = 1'b0;
    branch  = 1'b0;
    imm_sel = 1'b0;
    alu_op  = 2'd0;
    case (op)
      OP_ADD, OP_AND, OP_XOR, OP_LSH: begin
        rf_we  = 1'b1;
        alu_op = op[1:0];
      end
      OP_LDI: begin
        rf_we   = 1'b1;
        imm_sel = 1'b1;
      end
      OP_STR: str = 1'b1;
      OP_LDM: begin
        ldr   = 1'b1;
        rf_we = 1'b1;
      end
      OP_BNE: branch = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    op_d     = op;
    str_d    = str;
    ldr_d    = ldr;
    rf_we_d  = rf_we;
    branch_d = branch;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      str_q    <= 1'b0;
      ldr_q    <= 1'b0;
      rf_we_q  <= 1'b0;
      branch_q <= 1'b0;
    end else begin
      op_q     <= op_d;
      str_q    <= str_d;
      ldr_q    <= ldr_d;
      rf_we_q  <= rf_we_d;
      branch_q <= branch_d;
    end
  end

endmodule

// File: tb/tb_ctrl_decoder.sv
// Directed-vector and random-invariant bench for ctrl_decoder; expected values
// come from a hand-written truth table indexed by opcode.
module tb_ctrl_decoder;

  logic       clk;
  logic       reset;
  logic [2:0] op;
  logic       str, ldr, rf_we, branch, imm_sel;
  logic [1:0] alu_op;
  logic [2:0] op_q;
  logic       str_q, ldr_q, rf_we_q, branch_q;

  int checks = 0;
  int errors = 0;

  ctrl_decoder #(.OPW(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .str      (str),
    .ldr      (ldr),
    .rf_we    (rf_we),
    .branch   (branch),
    .imm_sel  (imm_sel),
    .alu_op   (alu_op),
    .op_q     (op_q),
    .str_q    (str_q),
    .ldr_q    (ldr_q),
    .rf_we_q  (rf_we_q),
    .branch_q (branch_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {str, ldr, rf_we, branch, imm_sel, alu_op[1:0]} per opcode.
  logic [6:0] golden [8];
  initial begin
    golden[0] = 7'b00100_00;
    golden[1] = 7'b00100_01;
    golden[2] = 7'b00100_10;
    golden[3] = 7'b00100_11;
    golden[4] = 7'b00101_00;
    golden[5] = 7'b10000_00;
    golden[6] = 7'b01100_00;
    golden[7] = 7'b00010_00;
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Changes op shortly after a rising edge and waits 5 ns before returning.
  task automatic applyStimulus(input logic [2:0] v);
    @(posedge clk);
    #2 op = v;
    #5;
  endtask

  function automatic logic [6:0] combVec();
    return {str, ldr, rf_we, branch, imm_sel, alu_op};
  endfunction

  logic [6:0] prev_exp;
  logic [2:0] prev_op;
  logic [6:0] exp_v;

  initial begin
    reset = 1'b1;
    op    = 3'd0;
    #12;
    checkOutput("reset_op_q", {5'd0, op_q}, 8'd0);
    checkOutput("reset_regs", {4'd0, str_q, ldr_q, rf_we_q, branch_q}, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'(i));
      checkOutput($sformatf("sweep_op%0d", i), {1'b0, combVec()}, {1'b0, golden[i]});
    end

    applyStimulus(3'd2);
    checkOutput("xor_alu_op", {6'd0, alu_op}, 8'd2);
    checkOutput("xor_imm_branch", {6'd0, imm_sel, branch}, 8'd0);
    applyStimulus(3'd4);
    checkOutput("ldi_imm_sel", {7'd0, imm_sel}, 8'd1);
    checkOutput("ldi_alu_op", {6'd0, alu_op}, 8'd0);
    applyStimulus(3'd7);
    checkOutput("bne_branch", {7'd0, branch}, 8'd1);

    // Registered latency: op=6 captured at edge n, then op=5 at edge n+1.
    applyStimulus(3'd6);
    @(posedge clk);
    #1;
    checkOutput("lat_n_ldr_rfwe", {6'd0, ldr_q, rf_we_q}, 8'b11);
    checkOutput("lat_n_op_q", {5'd0, op_q}, 8'd6);
    op = 3'd5;
    @(posedge clk);
    #1;
    checkOutput("lat_n1_str_q", {7'd0, str_q}, 8'd1);
    checkOutput("lat_n1_rf_we_q", {7'd0, rf_we_q}, 8'd0);

    // Asynchronous reset between edges.
    #3 reset = 1'b1;
    #1;
    checkOutput("arst_str_q", {7'd0, str_q}, 8'd0);
    checkOutput("arst_op_q", {5'd0, op_q}, 8'd0);
    checkOutput("arst_str_comb", {7'd0, str}, 8'd1);
    @(posedge clk);
    #1;
    checkOutput("arst_held", {1'b0, op_q, str_q, ldr_q, rf_we_q, branch_q}, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("arst_release_op_q", {5'd0, op_q}, 8'd5);
    checkOutput("arst_release_str_q", {7'd0, str_q}, 8'd1);

    // Unknown opcode bits must fall to the safe state (only when the simulator keeps X).
    applyStimulus(3'bx1x);
    if ($isunknown(op))
      checkOutput("x_safe", {3'd0, str, ldr, rf_we, branch, imm_sel}, 8'd0);
    else
      $display("[TB] note: X not representable, x_safe check skipped");

    // Random ops: invariants every cycle and registered copy vs previous decode.
    applyStimulus(3'd0);
    prev_exp = golden[0];
    prev_op  = 3'd0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      checkOutput("rnd_reg", {1'b0, op_q, str_q, ldr_q, rf_we_q, branch_q},
                  {1'b0, prev_op, prev_exp[6:3]});
      op = 3'($urandom_range(0, 7));
      #5;
      exp_v = golden[op];
      checkOutput("rnd_comb", {1'b0, combVec()}, {1'b0, exp_v});
      checkOutput("inv_str_rf_we", {7'd0, str & rf_we}, 8'd0);
      checkOutput("inv_ldr_rf_we", {7'd0, ldr & ~rf_we}, 8'd0);
      checkOutput("inv_onehot", {6'd0, 2'(32'(str) + 32'(ldr) + 32'(branch) + 32'(imm_sel) > 1)}, 8'd0);
      prev_exp = exp_v;
      prev_op  = op;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
